// File: rtl/multi_db_counter_amisha.sv
// Purpose : N_CH-channel button debouncer with raw/debounced edge event counters.
// Latency : 2-flop sync + 1 edge flop; debounced level after DB_N stable sample ticks; counts visible 1 cycle after edge.
// Backpressure: none, free-running; every qualifying edge is counted in the cycle it occurs.
//
// Ports:
//   clk_amisha        clock, rising edge
//   reset_amisha      asynchronous active-high reset
//   btn_amisha        raw asynchronous buttons, one bit per channel
//   clr_amisha        per-channel synchronous clear of counters and overflow flag
//   sel_amisha        channel routed to disp_amisha (out-of-range selects channel 0)
//   edge_mode_amisha  00 rising, 01 falling, 10 both, 11 none
//   sat_amisha        1 saturate counters, 0 wrap
//   db_level_amisha   debounced level per channel
//   db_tick_amisha    one-cycle pulse the cycle after a debounced level rises
//   disp_amisha       {raw_cnt[sel], db_cnt[sel]}
//   ovf_amisha        sticky per-channel overflow flag
module multi_db_counter_amisha #(
    parameter int N_CH     = 4,
    parameter int CW       = 8,
    parameter int SAMP_DIV = 500000,
    parameter int DB_N     = 3,
    localparam int SELW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_amisha,
    input  logic              reset_amisha,
    input  logic [N_CH-1:0]   btn_amisha,
    input  logic [N_CH-1:0]   clr_amisha,
    input  logic [SELW-1:0]   sel_amisha,
    input  logic [1:0]        edge_mode_amisha,
    input  logic              sat_amisha,
    output logic [N_CH-1:0]   db_level_amisha,
    output logic [N_CH-1:0]   db_tick_amisha,
    output logic [2*CW-1:0]   disp_amisha,
    output logic [N_CH-1:0]   ovf_amisha
);

    localparam int PW = $clog2(SAMP_DIV);
    localparam int KW = (DB_N > 1) ? $clog2(DB_N) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SAMP_DIV - 1);
    localparam logic [KW-1:0] K_MAX     = KW'(DB_N - 1);

    typedef enum logic {ST_STABLE, ST_CHANGING} db_state_t;

    logic [N_CH-1:0] sync_m, sync_s, sync_s_d;
    logic [PW-1:0]   presc_q;
    logic            samp_tick;

    db_state_t       state_q [N_CH];
    db_state_t       state_d [N_CH];
    logic [KW-1:0]   k_q     [N_CH];
    logic [KW-1:0]   k_d     [N_CH];
    logic [N_CH-1:0] lvl_q, lvl_d, lvl_dly;

    logic [CW-1:0]   raw_cnt [N_CH];
    logic [CW-1:0]   db_cnt  [N_CH];
    logic [N_CH-1:0] raw_ev, db_ev;

    function automatic logic edge_qual(input logic [1:0] mode, input logic rise, input logic fall);
        case (mode)
            2'b00:   return rise;
            2'b01:   return fall;
            2'b10:   return rise | fall;
            default: return 1'b0;
        endcase
    endfunction

    // Synchronizer, edge-detect delay and shared sample prescaler.
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            sync_m   <= '0;
            sync_s   <= '0;
            sync_s_d <= '0;
            presc_q  <= '0;
        end else begin
            sync_m   <= btn_amisha;
            sync_s   <= sync_m;
            sync_s_d <= sync_s;
            presc_q  <= (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
        end
    end

    assign samp_tick = (presc_q == PRESC_MAX);

    // Debounce FSM state registers.
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_STABLE;
                k_q[i]     <= '0;
            end
            lvl_q          <= '0;
            lvl_dly        <= '0;
            db_tick_amisha <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                k_q[i]     <= k_d[i];
            end
            lvl_q          <= lvl_d;
            lvl_dly        <= lvl_q;
            db_tick_amisha <= lvl_q & ~lvl_dly;
        end
    end

    // Next-state logic. Any tick that sees the input back at the current
    // level returns to STABLE with k=0, which is how a bounce restarts the count.
    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < N_CH; i++) begin
            logic [KW-1:0] k_cur;
            state_d[i] = state_q[i];
            k_d[i]     = k_q[i];
            k_cur      = (state_q[i] == ST_CHANGING) ? k_q[i] : '0;
            if (samp_tick) begin
                if (sync_s[i] == lvl_q[i]) begin
                    state_d[i] = ST_STABLE;
                    k_d[i]     = '0;
                end else if (k_cur == K_MAX) begin
                    lvl_d[i]   = ~lvl_q[i];
                    state_d[i] = ST_STABLE;
                    k_d[i]     = '0;
                end else begin
                    state_d[i] = ST_CHANGING;
                    k_d[i]     = k_cur + KW'(1);
                end
            end
        end
    end

    assign db_level_amisha = lvl_q;

    always_comb begin
        raw_ev = '0;
        db_ev  = '0;
        for (int i = 0; i < N_CH; i++) begin
            raw_ev[i] = edge_qual(edge_mode_amisha, sync_s[i] & ~sync_s_d[i], ~sync_s[i] & sync_s_d[i]);
            db_ev[i]  = edge_qual(edge_mode_amisha, lvl_q[i] & ~lvl_dly[i], ~lvl_q[i] & lvl_dly[i]);
        end
    end

    // Event counters; clear wins over a coincident edge.
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            for (int i = 0; i < N_CH; i++) begin
                raw_cnt[i] <= '0;
                db_cnt[i]  <= '0;
            end
            ovf_amisha <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (clr_amisha[i]) begin
                    raw_cnt[i]    <= '0;
                    db_cnt[i]     <= '0;
                    ovf_amisha[i] <= 1'b0;
                end else begin
                    if (raw_ev[i]) begin
                        if (&raw_cnt[i]) begin
                            ovf_amisha[i] <= 1'b1;
                            if (!sat_amisha) raw_cnt[i] <= '0;
                        end else begin
                            raw_cnt[i] <= raw_cnt[i] + CW'(1);
                        end
                    end
                    if (db_ev[i]) begin
                        if (&db_cnt[i]) begin
                            ovf_amisha[i] <= 1'b1;
                            if (!sat_amisha) db_cnt[i] <= '0;
                        end else begin
                            db_cnt[i] <= db_cnt[i] + CW'(1);
                        end
                    end
                end
            end
        end
    end

    // Display mux; unmatched select values fall back to channel 0.
    always_comb begin
        disp_amisha = {raw_cnt[0], db_cnt[0]};
        for (int i = 1; i < N_CH; i++) begin
            if (32'(sel_amisha) == 32'(i)) disp_amisha = {raw_cnt[i], db_cnt[i]};
        end
    end

endmodule

// File: doc/multi_db_counter_amisha.md
MULTI_DB_COUNTER_AMISHA -- requirements
Module: multi_db_counter_amisha

Interface
REQ-001 Parameter N_CH, default 4, number of button channels (2..16).
REQ-002 Parameter CW, default 8, width of each event counter (4..16).
REQ-003 Parameter SAMP_DIV, default 500000, clock cycles per debounce sample tick (>=2).
REQ-004 Parameter DB_N, default 3, consecutive stable sample ticks required to change debounced level (>=1).
REQ-005 Local SELW = max(1, clog2(N_CH)).
REQ-006 clk_amisha  in  1  single clock, all logic on rising edge.
REQ-007 reset_amisha  in  1  reset, asynchronous, active-high.
REQ-008 btn_amisha  in  N_CH  raw asynchronous button inputs.
REQ-009 clr_amisha  in  N_CH  per-channel synchronous clear of counters and overflow flag.
REQ-010 sel_amisha  in  SELW  channel shown on disp_amisha; values >= N_CH select channel 0.
REQ-011 edge_mode_amisha  in  2  00 rising, 01 falling, 10 both, 11 no counting.
REQ-012 sat_amisha  in  1  1 saturate counters at max, 0 wrap to 0.
REQ-013 db_level_amisha  out  N_CH  debounced level per channel.
REQ-014 db_tick_amisha  out  N_CH  one-cycle pulse per debounced rising edge.
REQ-015 disp_amisha  out  2*CW  {raw_cnt[sel], db_cnt[sel]}, for the hex display mux.
REQ-016 ovf_amisha  out  N_CH  sticky per-channel overflow flag (either counter).

Function
REQ-017 Each btn bit SHALL pass a 2-flop synchronizer; sync value s[i] SHALL also be delayed one flop (s_d[i]) for edge detection.
REQ-018 Raw edge of channel i: rise = s & ~s_d, fall = ~s & s_d, computed from registered signals.
REQ-019 Shared prescaler counts 0..SAMP_DIV-1 free-running; sample tick is high one cycle when prescaler == SAMP_DIV-1.
REQ-020 Per-channel debounce FSM, states STABLE and CHANGING, with level L and stability count k (0..DB_N-1).
REQ-021 Only on sample tick: s == L -> STABLE, k=0; s != L and k < DB_N-1 -> CHANGING, k+1; s != L and k == DB_N-1 -> L toggles, k=0, STABLE.
REQ-022 A bounce (s returns to L at any tick while CHANGING) SHALL restart the count from 0.
REQ-023 db_level_amisha[i] = L[i] (registered); db_tick_amisha[i] high exactly the cycle after L[i] rises, independent of edge_mode.
REQ-024 raw_cnt[i] increments on raw edges, db_cnt[i] on debounced L edges, both qualified by edge_mode_amisha; new value visible the cycle after the qualifying edge.
REQ-025 clr_amisha[i] SHALL have priority: counters and ovf of channel i go to 0 next cycle; a coincident edge is discarded.
REQ-026 Increment from all-ones: sat=1 holds all-ones, sat=0 wraps to 0; in both cases ovf_amisha[i] sets and stays set until clr or reset.
REQ-027 raw_cnt and db_cnt of one channel update independently; simultaneous edges on different channels SHALL all be counted in the same cycle.
REQ-028 edge_mode/sat/sel changes take effect on the next clock edge; no count is retroactively altered.
REQ-029 disp_amisha is combinational from counters and sel_amisha.

Reset
REQ-030 While reset_amisha is high: synchronizers, s_d, prescaler, L, k, all counters, ovf, db_tick SHALL be 0; FSMs in STABLE; disp_amisha = 0.
REQ-031 Reset asserted mid-debounce SHALL discard progress; after release prescaler restarts from 0.

Verification (SAMP_DIV=4, DB_N=3, N_CH=4, CW=4, edge_mode=00, sat=0)
REQ-032 Clean press held 20 cycles on ch0 -> db_level[0] rises after third sample tick with input high; db_tick[0] one pulse; disp {1,1} with sel=0.
REQ-033 Press with 3 bounces (toggles 2 cycles each) then held -> raw_cnt=4, db_cnt=1; db_level rises only after 3 clean ticks.
REQ-034 16 clean presses on ch1 -> raw_cnt and db_cnt wrap to 0, ovf[1]=1; repeat with sat=1 -> both hold 15, ovf[1]=1.
REQ-035 clr[2] asserted in same cycle as debounced edge on ch2 -> counters 0, ovf[2]=0, edge not counted; other channels unaffected.
REQ-036 edge_mode=10, one press/release on ch3 -> raw_cnt=2, db_cnt=2; edge_mode=11 -> counts unchanged.
REQ-037 reset pulse while ch0 is CHANGING (k=2) -> all outputs 0; after release, held input needs full 3 ticks to debounce.
